uart_tx: RTL

//  Serial transmitter fed by the divided baud clock from the frequency divider stage.

---
 rtl/udar_uart_pkg.sv | 24 ++
 rtl/uart_baud_edge.sv | 44 ++++
 rtl/uart_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/udar_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udar_uart_pkg
// Purpose  : Shared definitions for the UART transmitter: 3-bit state
//            encoding and default frame parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package udar_uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ALIGN  = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;
  localparam state_t ST_STOP   = 3'd5;

  localparam int DEF_DATA_LEN  = 8;
  localparam int DEF_STOP_BITS = 1;

endpackage : udar_uart_pkg
`default_nettype wire

// File: rtl/uart_baud_edge.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_edge
// Purpose  : Brings the divided baud clock into the clk domain through a
//            two-flop synchroniser and turns each rising edge into a
//            registered one-cycle tick. The tick is high for exactly one clk,
//            three clk edges after baud_clk rises.
// Ports    : clk      in  system clock
//            rst      in  asynchronous active-low reset
//            baud_clk in  divided baud clock (asynchronous to clk)
//            tick     out one-cycle bit tick
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_edge (
  input  logic clk,
  input  logic rst,
  input  logic baud_clk,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= baud_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // Registered so the tick is a clean single-cycle pulse
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick = tick_q;

endmodule : uart_baud_edge
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Serial transmitter. Accepts one word per frame over a
//            valid/ready handshake and sends start bit, DATA_LEN data bits
//            LSB first, optional parity bit and STOP_BITS stop bits on txd.
//            Bit timing comes from the rising edges of baud_clk.
// Config   : define UART_TX_PARITY_EN to insert a parity bit after the data
//            (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
//            Without the macro there is no parity logic at all.
// Ports    : clk      in  system clock
//            rst      in  asynchronous active-low reset
//            baud_clk in  divided baud clock
//            tx_data  in  word to send [DATA_LEN-1:0]
//            tx_valid in  tx_data is valid
//            tx_ready out transmitter can accept a word (IDLE only)
//            txd      out serial line, idle high
//            busy     out frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import udar_uart_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_clk,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                txd,
  output logic                busy
);

  localparam int CNT_W = $clog2(DATA_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  logic                tick;
  logic                accept;
  logic [DATA_LEN-1:0] shift_nxt;

  state_t              state_q;
  logic [DATA_LEN-1:0] shift_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                txd_q;
  logic                ready_q;
  logic                busy_q;

`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`else
  logic                unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_baud_edge u_baud_edge (
    .clk      (clk),
    .rst      (rst),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  assign accept    = tx_valid & ready_q;
  assign shift_nxt = shift_q >> 1;

  // Outputs are registered: txd is loaded with the value of the bit that
  // the state being entered will drive, so it changes on the tick edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A tick arriving together with the accept is deliberately
          // ignored; ALIGN waits for the next one.
          if (accept) begin
            state_q <= ST_ALIGN;
            shift_q <= tx_data;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
          end
        end

        ST_ALIGN: begin
          if (tick) begin
            state_q <= ST_START;
            txd_q   <= 1'b0;
          end
        end

        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
          end
        end

        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_nxt;
            if (bit_cnt_q == LAST_DATA) begin
              // Counter is reused to count stop bits
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              txd_q     <= parity_q;
`else
              state_q   <= ST_STOP;
              txd_q     <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              txd_q     <= shift_nxt[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state_q   <= ST_STOP;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q   <= ST_IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            txd_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          txd_q     <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign busy     = busy_q;

endmodule : uart_tx
`default_nettype wire
